input_conditioner: RTL and testbench

- Sits directly upstream of the pulse-sequence detector. Turns a raw, asynchronous, bouncing pushbutton or switch line into a clean level and a single-cycle rising-edge pulse.
- The pulse drives the detector's `insig` input.
- Contents: two-flop synchronizer, debounce FSM with stable-sample counter, registered edge pulse.

---
 rtl/input_conditioner_pkg.sv | 25 ++
 rtl/input_conditioner_sync2.sv | 27 ++
 rtl/input_conditioner.sv | 104 ++++++++++
 tb/tb_input_conditioner.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner_pkg
// Brief    : Shared state encoding, default debounce length and width helper
//            for the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b10,
        WAIT_LOW  = 2'b11
    } state_e;

    // A single-cycle debounce still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_sync2.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner_sync2
// Brief    : Two-flop synchronizer bringing an asynchronous line into clk.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Synchronizes and debounces a raw button line, producing a clean
//            level and a one-cycle pulse on each accepted press.
//            Define INPUT_INVERT_EN for active-low keys.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic insig
);

    localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_cond;
    logic             sync_q;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             insig_q;

`ifdef INPUT_INVERT_EN
    assign raw_cond = ~raw_in;
`else
    assign raw_cond = raw_in;
`endif

    input_conditioner_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_cond),
        .q     (sync_q)
    );

    // The pulse is only ever raised on the WAIT_HIGH -> IDLE_HIGH edge, so
    // clearing it by default everywhere else yields exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            insig_q <= 1'b0;
        end else begin
            insig_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_q) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_q) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        insig_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_q) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_q) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign insig = insig_q;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_in;
    logic level;
    logic insig;

    always #5 clk = ~clk;

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw_in),
        .level  (level),
        .insig  (insig)
    );

    typedef struct {
        logic raw;
        logic exp_level;
        logic exp_insig;
    } vec_t;

    typedef struct {
        logic level;
        logic insig;
        int   idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Logical key value -> pin value (active-low keys when inverted).
    function automatic logic phys(input logic v);
`ifdef INPUT_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // n cycles of raw; level is pre before index sw and post from sw on;
    // a pulse, if any, is expected exactly at index sw.
    task automatic add(input logic raw, input int n, input logic pre, input logic post,
                       input int sw, input logic pulse);
        for (int i = 0; i < n; i++)
            vecs.push_back('{raw: raw,
                             exp_level: (i < sw) ? pre : post,
                             exp_insig: pulse && (i == sw)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        raw_in = phys(1'b0);
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_level", level, 0);
        check("reset_insig", insig, 0);
        check("reset_state", dut.state_q, 0);
        check("reset_cnt", dut.cnt_q, 0);
        @(negedge clk) reset = 1'b0;

        add(1'b0,   4, 1'b0, 1'b0,   4, 1'b0);  // idle
        add(1'b1,  20, 1'b0, 1'b1,   6, 1'b1);  // clean press
        add(1'b0,   3, 1'b1, 1'b1,   3, 1'b0);  // short low glitch while high
        add(1'b1,   6, 1'b1, 1'b1,   6, 1'b0);
        add(1'b0,  10, 1'b1, 1'b0,   6, 1'b0);  // release
        add(1'b1,   3, 1'b0, 1'b0,   3, 1'b0);  // short high glitch
        add(1'b0,   6, 1'b0, 1'b0,   6, 1'b0);
        add(1'b1,   1, 1'b0, 1'b0,   1, 1'b0);  // bounce 1,0,1,0
        add(1'b0,   1, 1'b0, 1'b0,   1, 1'b0);
        add(1'b1,   1, 1'b0, 1'b0,   1, 1'b0);
        add(1'b0,   1, 1'b0, 1'b0,   1, 1'b0);
        add(1'b1,  12, 1'b0, 1'b1,   6, 1'b1);  // settles high
        add(1'b0,  10, 1'b1, 1'b0,   6, 1'b0);
        add(1'b1, 100, 1'b0, 1'b1,   6, 1'b1);  // long hold, one pulse
        add(1'b0,  10, 1'b1, 1'b0,   6, 1'b0);

        foreach (vecs[k]) begin
            @(negedge clk);
            raw_in = phys(vecs[k].raw);
            sb.push_back('{level: vecs[k].exp_level, insig: vecs[k].exp_insig, idx: k});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d_level", e.idx), level, e.level);
            check($sformatf("vec%0d_insig", e.idx), insig, e.insig);
        end

        // Reset asynchronously while WAIT_HIGH with cnt=2.
        @(negedge clk) raw_in = phys(1'b1);
        repeat (5) @(posedge clk);
        #2;
        check("mid_state_pre", dut.state_q, 1);
        check("mid_cnt_pre", dut.cnt_q, 2);
        #1 reset = 1'b1;
        #1;
        check("mid_state_rst", dut.state_q, 0);
        check("mid_cnt_rst", dut.cnt_q, 0);
        check("mid_level_rst", level, 0);
        check("mid_insig_rst", insig, 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rel%0d_insig", i), insig, (i == 6));
            check($sformatf("rel%0d_level", i), level, (i >= 6));
        end

        // Reset while the pulse is high: it must drop without waiting for clk.
        @(negedge clk) reset = 1'b1;
        #1 check("pulse_rst_level", level, 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) check("pulse_high", insig, 1);
        end
        #2 reset = 1'b1;
        #1;
        check("pulse_drop_insig", insig, 0);
        check("pulse_drop_level", level, 0);
        @(negedge clk);
        raw_in = phys(1'b0);
        reset  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("after%0d_insig", i), insig, 0);
            check($sformatf("after%0d_level", i), level, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
